// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memsys port between instruction fetch and exec_unit data accesses,
// tracking one outstanding read. Define MEM_ARB_RR_EN for round-robin tie-breaking.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] BUSY      = 1'b1;
  localparam logic       OWN_FETCH = 1'b0;
  localparam logic       OWN_DATA  = 1'b1;
  localparam logic [2:0] LAT_C     = 3'(RD_LATENCY);

  logic [0:0] state;
  logic [2:0] cnt;
  logic       owner;
  logic       data_wins;
  logic       grant_d;
  logic       grant_f;
  logic       rd_issue;
  logic       cap_p0;

`ifdef MEM_ARB_RR_EN
  logic last_gnt;

  // On a tie the port not granted last time wins; updated on every grant.
  assign data_wins = (last_gnt == OWN_FETCH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt <= OWN_FETCH;
    end else if (grant_d || grant_f) begin
      last_gnt <= grant_d ? OWN_DATA : OWN_FETCH;
    end
  end
`else
  assign data_wins = 1'b1;
`endif

  // Grants are combinational and forced low while reset is asserted.
  always_comb begin
    grant_d = 1'b0;
    grant_f = 1'b0;
    if (reset_n && state == IDLE) begin
      if (d_req && (!if_req || data_wins)) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_f = 1'b1;
      end
    end
  end

  assign if_gnt      = grant_f;
  assign d_gnt       = grant_d;
  assign rd_issue    = grant_f || (grant_d && !d_we);
  assign mem_rd_en   = rd_issue;
  assign mem_rd_addr = grant_f ? if_addr : ((grant_d && !d_we) ? d_addr : '0);
  assign mem_wr_en   = grant_d && d_we;
  assign mem_wr_addr = (grant_d && d_we) ? d_addr : '0;
  assign mem_wr_data = (grant_d && d_we) ? d_wdata : '0;

  assign cap_p0 = (state == BUSY) && (cnt == LAT_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= OWN_FETCH;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
    end else begin
      if_rvalid <= cap_p0 && (owner == OWN_FETCH);
      d_rvalid  <= cap_p0 && (owner == OWN_DATA);
      case (state)
        IDLE: begin
          if (rd_issue) begin
            state <= BUSY;
            cnt   <= 3'd1;
            owner <= grant_d ? OWN_DATA : OWN_FETCH;
          end
        end
        default: begin
          if (cap_p0) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
      endcase
    end
  end

  // Capture stage: returned data lands in the owner's register, which holds until its next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (cap_p0) begin
      if (owner == OWN_DATA) begin
        d_rdata <= mem_rd_data;
      end else begin
        if_rdata <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two instances (read latency 1 and 3) share stimulus
// and are compared each cycle against a cycle-count based reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] mem_rd_data = '0;

  logic        if_gnt [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata [2];
  logic        d_gnt [2];
  logic        d_rvalid [2];
  logic [31:0] d_rdata [2];
  logic        mem_rd_en [2];
  logic [31:0] mem_rd_addr [2];
  logic        mem_wr_en [2];
  logic [31:0] mem_wr_addr [2];
  logic [31:0] mem_wr_data [2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_rd_en(mem_rd_en[0]), .mem_rd_addr(mem_rd_addr[0]), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en[0]), .mem_wr_addr(mem_wr_addr[0]), .mem_wr_data(mem_wr_data[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_rd_en(mem_rd_en[1]), .mem_rd_addr(mem_rd_addr[1]), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en[1]), .mem_wr_addr(mem_wr_addr[1]), .mem_wr_data(mem_wr_data[1])
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int rst_hold = 3;

  // Reference model state, one slot per instance.
  int          lat [2] = '{1, 3};
  int          free_at [2];
  int          ret_c [2];
  bit          pend [2];
  bit          own_d [2];
  bit          last_d [2];
  bit          exp_ifrv [2];
  bit          exp_drv [2];
  logic [31:0] exp_ifrd [2];
  logic [31:0] exp_drd [2];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    free_at[k]  = 0;
    ret_c[k]    = 0;
    pend[k]     = 1'b0;
    own_d[k]    = 1'b0;
    last_d[k]   = 1'b0;
    exp_ifrv[k] = 1'b0;
    exp_drv[k]  = 1'b0;
    exp_ifrd[k] = '0;
    exp_drd[k]  = '0;
  endtask

  task automatic model_cycle(input int k);
    bit          gd, gf, erd, ewr;
    logic [31:0] e_rd_addr, e_wr_addr, e_wr_data;
    string       p;
    p  = $sformatf("L%0d", lat[k]);
    gd = 1'b0;
    gf = 1'b0;
    if (!reset_n) model_reset(k);
    if (reset_n && cyc >= free_at[k]) begin
      if (d_req && if_req) begin
`ifdef MEM_ARB_RR_EN
        gd = !last_d[k];
        gf = last_d[k];
`else
        gd = 1'b1;
`endif
      end else begin
        gd = d_req;
        gf = if_req;
      end
    end
    erd       = gf || (gd && !d_we);
    ewr       = gd && d_we;
    e_rd_addr = gf ? if_addr : ((gd && !d_we) ? d_addr : 32'h0);
    e_wr_addr = ewr ? d_addr : 32'h0;
    e_wr_data = ewr ? d_wdata : 32'h0;

    chk_val({p, " if_gnt"}, 32'(if_gnt[k]), 32'(gf));
    chk_val({p, " d_gnt"}, 32'(d_gnt[k]), 32'(gd));
    chk_val({p, " mem_rd_en"}, 32'(mem_rd_en[k]), 32'(erd));
    chk_val({p, " mem_rd_addr"}, mem_rd_addr[k], e_rd_addr);
    chk_val({p, " mem_wr_en"}, 32'(mem_wr_en[k]), 32'(ewr));
    chk_val({p, " mem_wr_addr"}, mem_wr_addr[k], e_wr_addr);
    chk_val({p, " mem_wr_data"}, mem_wr_data[k], e_wr_data);
    chk_val({p, " if_rvalid"}, 32'(if_rvalid[k]), 32'(exp_ifrv[k]));
    chk_val({p, " d_rvalid"}, 32'(d_rvalid[k]), 32'(exp_drv[k]));
    chk_val({p, " if_rdata"}, if_rdata[k], exp_ifrd[k]);
    chk_val({p, " d_rdata"}, d_rdata[k], exp_drd[k]);

    if (reset_n) begin
      exp_ifrv[k] = 1'b0;
      exp_drv[k]  = 1'b0;
      if (pend[k] && cyc == ret_c[k]) begin
        pend[k] = 1'b0;
        if (own_d[k]) begin
          exp_drv[k] = 1'b1;
          exp_drd[k] = mem_rd_data;
        end else begin
          exp_ifrv[k] = 1'b1;
          exp_ifrd[k] = mem_rd_data;
        end
      end
      if (gd || gf) last_d[k] = gd;
      if (erd) begin
        pend[k]    = 1'b1;
        own_d[k]   = gd;
        ret_c[k]   = cyc + lat[k];
        free_at[k] = cyc + lat[k] + 1;
      end
    end
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_hold > 0) begin
        reset_n  = 1'b0;
        rst_hold = rst_hold - 1;
      end else if ($urandom_range(0, 79) == 0) begin
        reset_n  = 1'b0;
        rst_hold = $urandom_range(0, 2);
      end else begin
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = $urandom;
      end
      if ($urandom_range(0, 2) == 0) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      mem_rd_data = $urandom;
      @(negedge clk);
      model_cycle(0);
      model_cycle(1);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
